ccff_chain_loader: RTL
======================

// Module: ccff_chain_loader
// PURPOSE
//  Sequences the configuration-chain (ccff) load of a logic tile such as the frac_lut6 tile
//  (64 LUT SRAM bits + 1 mode bit = 65 flops). A host streams bitstream words over valid/ready.
//  The block serialises them onto ccff_head, one bit per prog_clk, and asserts chain_shift_en
//  to drive the external prog_clk gate. It reports busy/done and, optionally, a readback checksum error.
// PARAMETERS
//  CHAIN_LEN  65  number of ccff flops in the driven chain (>=1)
//  WORD_W     8   host word width (1..32)
// PORTS
//  prog_clk        in   1        single clock; chain flops are clocked by gated prog_clk
//  pReset          in   1        synchronous, active-high reset
//  start           in   1        1-cycle pulse: begin a load (ignored unless IDLE)
//  cfg_valid       in   1        host word valid
//  cfg_data        in   WORD_W   host word, consumed LSB first
//  cfg_ready       out  1        word accepted when cfg_valid & cfg_ready
//  chain_shift_en  out  1        1 = chain shifts this cycle (prog_clk gate enable)
//  ccff_head       out  1        serial bit into chain; meaningful only when chain_shift_en=1
//  ccff_tail       in   1        serial bit out of chain (last flop Q, no pipeline)
//  busy            out  1        high from cycle after start until done
//  done            out  1        1-cycle pulse at end of load (and verify)
//  cfg_error       out  1        sticky; cleared by start; only driven in CCFF_READBACK_EN builds
// BEHAVIOUR
//  Reset: state=IDLE; cfg_ready, chain_shift_en, ccff_head, busy, done, cfg_error = 0;
//    bit counter and word buffer cleared. pReset mid-load aborts immediately; chain contents undefined.
//  FSM: IDLE -start-> LOAD -(CHAIN_LEN bits shifted)-> VERIFY (readback) or FIN -> IDLE.
//    FIN lasts 1 cycle: done=1, busy=0.
//  LOAD: 1-word buffer (bit ptr 0..WORD_W-1).
//    cfg_ready=1 when buffer empty or when the last needed buffer bit is shifted this cycle.
//    This gives sustained 1 bit/cycle with no bubble.
//    A word accepted at edge t shifts bit0 in cycle t+1.
//    chain_shift_en=1 only in cycles where a buffered bit is available; host stalls -> chain holds.
//    Stream bit k (k=0..CHAIN_LEN-1) = word k/WORD_W, bit k%WORD_W.
//    In the final word, bits beyond CHAIN_LEN are discarded and the buffer is flushed.
//    Exactly ceil(CHAIN_LEN/WORD_W) words are accepted per load.
//    cfg_ready=0 after the final word and in all other states.
//  Bit counter width $clog2(CHAIN_LEN+1); LOAD exits on the cycle shifting bit CHAIN_LEN-1.
//  start while busy: ignored. cfg_valid outside LOAD: ignored, no handshake.
//  Bit k shifted first ends at the far (mode) end after CHAIN_LEN shifts.
// CONFIGURATION
//  CCFF_READBACK_EN defined:
//    During LOAD, CRC-8 (poly 0x07, init 0x00, MSB-first update) runs over shifted bits in order.
//    VERIFY: CHAIN_LEN shift cycles; ccff_head=ccff_tail (recirculate, config preserved),
//      chain_shift_en=1 every cycle.
//    A second CRC-8 runs over the sampled tail bits. On exit, cfg_error=(crc_load!=crc_tail),
//      set in the same cycle done pulses.
//  CCFF_READBACK_EN undefined: no VERIFY state, no CRC logic; cfg_error tied 0.
// STRUCTURE
//  ccff_loader_pkg: state enum {IDLE,LOAD,VERIFY,FIN}; CRC8_POLY=8'h07; function crc8_next(crc,bit).
//  Sub-module ccff_crc8 (clear, en, bit_in -> crc[7:0]), instanced twice under CCFF_READBACK_EN.
// TESTING (CHAIN_LEN=65, WORD_W=8, 65-flop shift-register chain model)
//  1 No stall: start@0, cfg_valid held, 9 words.
//    -> shift_en high cycles 2..66, done@67, chain model == stream bits 0..64.
//  2 Host stalls 5 cycles before word 3 -> shift_en low 5 cycles, chain unchanged; done@72; contents match.
//  3 Word 8 = 8'hFE -> only bit0 (0) loaded; cfg_ready low after word 8; 10th word never accepted.
//  4 pReset at cycle 30 -> next cycle all outputs 0, IDLE.
//    New start loads full 65 bits correctly.
//  5 start pulsed during LOAD -> ignored, done exactly once.
//    With CCFF_READBACK_EN: clean chain -> cfg_error=0, done@132, contents intact.
//  6 CCFF_READBACK_EN, model flips chain flop 10 before VERIFY -> cfg_error=1 with done; cleared by next start.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared state encoding and CRC-8 step for the ccff chain loader
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    FIN
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One MSB-first CRC-8 step over a single serial bit.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8.sv
// rtl/ccff_crc8.sv - serial CRC-8 accumulator (poly 0x07, init 0x00, MSB-first)
module ccff_crc8
  import ccff_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises host words onto a ccff configuration chain
// Optional readback/CRC verify pass is built when CCFF_READBACK_EN is defined.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 65,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              chain_shift_en,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              cfg_error
);

  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int PTR_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] buf_data;
  logic              buf_valid;
  logic [PTR_W-1:0]  bit_ptr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WCNT_W-1:0] word_cnt;

  logic last_bit;
  logic ptr_last;
  logic shift_load;
  logic accept;
  logic load_start;

  assign last_bit   = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign ptr_last   = (bit_ptr == PTR_W'(WORD_W - 1));
  assign shift_load = (state == LOAD) && buf_valid;
  assign accept     = cfg_valid && cfg_ready;
  assign load_start = (state == IDLE) && start;

  always_comb begin
    state_next     = state;
    cfg_ready      = 1'b0;
    chain_shift_en = 1'b0;
    ccff_head      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        busy           = 1'b1;
        // Refill while the last buffered bit is still shifting keeps 1 bit/cycle.
        cfg_ready      = (word_cnt < WCNT_W'(NUM_WORDS)) && (!buf_valid || ptr_last);
        chain_shift_en = buf_valid;
        ccff_head      = buf_valid & buf_data[bit_ptr];
        if (shift_load && last_bit) begin
`ifdef CCFF_READBACK_EN
          state_next = VERIFY;
`else
          state_next = FIN;
`endif
        end
      end
`ifdef CCFF_READBACK_EN
      VERIFY: begin
        busy           = 1'b1;
        chain_shift_en = 1'b1;
        ccff_head      = ccff_tail;
        if (last_bit) state_next = FIN;
      end
`endif
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state     <= IDLE;
      buf_data  <= '0;
      buf_valid <= 1'b0;
      bit_ptr   <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      state <= state_next;
      if (load_start) begin
        buf_valid <= 1'b0;
        bit_ptr   <= '0;
        bit_cnt   <= '0;
        word_cnt  <= '0;
      end
      if (shift_load) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        // The final word may carry bits past the chain end; drop them.
        if (ptr_last || last_bit) begin
          buf_valid <= 1'b0;
          bit_ptr   <= '0;
        end else begin
          bit_ptr <= bit_ptr + 1'b1;
        end
      end
`ifdef CCFF_READBACK_EN
      if (state == VERIFY) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
`endif
      if (accept) begin
        buf_data  <= cfg_data;
        buf_valid <= 1'b1;
        bit_ptr   <= '0;
        word_cnt  <= word_cnt + 1'b1;
      end
    end
  end

`ifdef CCFF_READBACK_EN
  logic [7:0] crc_load;
  logic [7:0] crc_tail;
  logic       err_q;

  ccff_crc8 u_crc_load (
    .clk    (prog_clk),
    .rst    (pReset),
    .clear  (load_start),
    .en     (shift_load),
    .bit_in (ccff_head),
    .crc    (crc_load)
  );

  ccff_crc8 u_crc_tail (
    .clk    (prog_clk),
    .rst    (pReset),
    .clear  (load_start),
    .en     (state == VERIFY),
    .bit_in (ccff_tail),
    .crc    (crc_tail)
  );

  // Fold in the final tail bit directly so the verdict lands with done.
  always_ff @(posedge prog_clk) begin
    if (pReset || load_start) begin
      err_q <= 1'b0;
    end else if ((state == VERIFY) && last_bit) begin
      err_q <= (crc_load != crc8_next(crc_tail, ccff_tail));
    end
  end

  assign cfg_error = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign cfg_error   = 1'b0;
`endif

endmodule
